// File: rtl/cpu_pkg.sv
// Shared RV32 core definitions: control-path pc_sel encodings, the NOP word and
// the fetch FSM state type. FETCH_MISALIGN_TRAP_EN adds the FAULT state.
package cpu_pkg;

  localparam logic [2:0] ALU_OUT = 3'b000;
  localparam logic [2:0] NEXT_PC = 3'b010;
  localparam logic [2:0] IMM_PC  = 3'b011;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {REQ, WAIT, HOLD, FAULT} fetch_state_e;
`else
  typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_e;
`endif

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selector shared by fetch and the future branch predictor.
// Reports the raw target and whether its low two bits are non-zero.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  // NOTE: every output of a combinational block gets a value on every path
  // (here via the default arm) so no latch is inferred.
  always_comb begin
    case (pc_sel)
      ALU_OUT: target = alu_result & ~XLEN'(1);  // jalr clears bit 0
      IMM_PC:  target = pc + imm;
      NEXT_PC: target = pc + XLEN'(4);
      default: target = pc + XLEN'(4);
    endcase
  end

  assign misaligned = |target[1:0];

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: one outstanding imem request, holds the fetched
// instruction until commit. FETCH_MISALIGN_TRAP_EN enables the sticky FAULT trap.
module fetch_unit #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_3000,
  parameter logic [31:0]      NOP_INSN = cpu_pkg::NOP_INSN
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  output logic [XLEN-1:0] ir_pc,
  output logic            ir_valid,
  input  logic            commit,
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic            fetch_fault
);

  cpu_pkg::fetch_state_e state_q, state_d;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_pc_q, ir_pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            req_q, req_d;
  logic            ir_valid_q, ir_valid_d;
  logic [XLEN-1:0] target;
  logic            misaligned;

  next_pc_calc #(
    .XLEN(XLEN)
  ) u_next_pc (
    .pc         (pc_q),
    .pc_sel     (pc_sel),
    .imm        (imm),
    .alu_result (alu_result),
    .target     (target),
    .misaligned (misaligned)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign fetch_fault = fault_q;
`else
  logic [XLEN-1:0] aligned_target;
  assign aligned_target = misaligned ? {target[XLEN-1:2], 2'b00} : target;
  assign fetch_fault    = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= cpu_pkg::REQ;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      ir_q       <= NOP_INSN;
      ir_pc_q    <= RESET_PC;
      ir_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q    <= fault_d;
`endif
    end
  end

  // imem_req is registered so it stays low for the first cycle out of reset
  // and rises in the same edge that commits, giving a 1-cycle restart.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d    = fault_q;
`endif
    case (state_q)
      cpu_pkg::REQ: begin
        req_d = 1'b1;
        if (req_q && imem_ready) begin
          state_d = cpu_pkg::WAIT;
          req_d   = 1'b0;
        end
      end
      cpu_pkg::WAIT: begin
        req_d = 1'b0;
        if (imem_rvalid) begin
          ir_d       = imem_rdata;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          state_d    = cpu_pkg::HOLD;
        end
      end
      cpu_pkg::HOLD: begin
        if (commit) begin
          ir_valid_d = 1'b0;
          ir_d       = NOP_INSN;
`ifdef FETCH_MISALIGN_TRAP_EN
          pc_d = target;
          if (misaligned) begin
            state_d = cpu_pkg::FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = cpu_pkg::REQ;
            req_d   = 1'b1;
          end
`else
          pc_d    = aligned_target;
          state_d = cpu_pkg::REQ;
          req_d   = 1'b1;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      cpu_pkg::FAULT: begin
        req_d      = 1'b0;
        ir_valid_d = 1'b0;
      end
`endif
      default: begin
        state_d = cpu_pkg::REQ;
        req_d   = 1'b0;
      end
    endcase
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;

endmodule
